preempt_irq_controller: RTL and testbench
=========================================

// Module: preempt_irq_controller
// PURPOSE
// - Preemption timer and interrupt sequencer for the single-cycle MIPS core.
// - Counts retired instructions against a quantum loaded by the set-clock instruction.
// - Latches timer and keyboard events and redirects fetch to the ISR vector at an instruction boundary.
// - Holds the interrupted PC for the save-PC-buffer instruction and the cause word for the get-interruption instruction.
// PARAMETERS
// - DATA_W      32     register/data width
// - PC_W        10     instruction-memory address width
// - CNT_W       16     quantum counter width
// - ISR_VECTOR  10'd1  handler entry address (PC_W bits)
// PORTS
// - clock         in   1       system clock; all state updates on its rising edge
// - reset         in   1       asynchronous reset, active-high
// - step          in   1       instruction retires this cycle (clock enable high and Halt low)
// - halt          in   1       decoded Halt
// - set_clock     in   1       decoded set-clock; qualified by step
// - set_value     in   DATA_W  rs value for set-clock; [CNT_W-1:0] = quantum
// - get_irq       in   1       decoded get-interruption; qualified by step
// - kbd_valid     in   1       one-cycle pulse: keyboard byte arrived
// - pc_next       in   PC_W    PC the core would fetch next
// - irq_take      out  1       this edge: PC <= isr_vector, saved_pc <= pc_next
// - isr_vector    out  PC_W    constant ISR_VECTOR
// - saved_pc      out  PC_W    interrupted PC (save-PC-buffer source)
// - cause         out  DATA_W  {DATA_W-2 zeros, kbd_pend, tmr_pend}
// - in_isr        out  1       high while the handler runs
// BEHAVIOUR
// Reset (async, immediate)
// - State RUN; count=0; quantum=0; both pend bits 0; saved_pc=0.
// - Outputs: irq_take=0, cause=0, in_isr=0, isr_vector=ISR_VECTOR.
// - Reset mid-ISR discards all pending events.
// Timer
// - set_clock & step: quantum <= set_value[CNT_W-1:0]; count <= same value.
// - Quantum 0 disables the timer.
// - RUN & step & count!=0 & not set_clock: count decrements.
// - Transition count 1->0 sets tmr_pend and auto-reloads count <= quantum in the same edge.
// - Counter is frozen in ISR; set_clock in ISR still loads it.
// Events
// - kbd_valid sets kbd_pend in any state, including while halted.
// - get_irq & step: cause is driven combinationally from the pend bits, then both bits clear at that edge.
// - A set and a clear of the same bit on the same edge: set wins, so the event is never lost.
// FSM (2 states)
// - RUN --(tmr_pend|kbd_pend) & step & !halt--> ISR.
// - irq_take is a Mealy output, combinationally high exactly on that cycle.
// - On that edge: saved_pc <= pc_next; the core loads PC <= isr_vector instead of pc_next.
// - ISR --set_clock & step--> RUN; the handler's re-arm acts as the return.
//   - The handler ends with set-clock, then jr to the buffered PC.
// - In ISR, new events latch but irq_take stays 0.
// - Pend bits still set on return trigger a take at the next step.
// - Halt blocks a take; pend bits persist.
// - saved_pc changes only on irq_take.
// Latency
// - Event to redirect: at most one retired instruction, since the take happens on the first step with pend set.
// - Timer expiry and take may fall on the same edge only if pend was already set; otherwise the take is one step later.
// STRUCTURE
// - Package cpu_irq_pkg:
//   - CAUSE_TMR=0, CAUSE_KBD=1
//   - state enum {RUN, ISR}
//   - opcode constants SETCLK=6'b000001, GETIRQ=6'b000110, SAVEPCB=6'b110100, ISR_VECTOR default
// - Sub-module quantum_counter: load/dec/reload; outputs expire; CNT_W param.
// - Top: pend latches, FSM, saved_pc register.
// TESTING
// 1. Reset while in_isr=1 with kbd_pend=1 -> in_isr=0, cause=0, irq_take=0, count=0 immediately.
// 2. set_clock quantum=3, then 3 steps -> tmr_pend after 3rd step; 4th step (pc_next=0x24) -> irq_take=1, saved_pc=0x24, in_isr=1.
// 3. kbd_valid in ISR -> no take; get_irq -> cause=0x2, then 0; set_clock -> RUN; next step takes if pend re-set.
// 4. kbd_valid and get_irq on the same edge -> kbd_pend remains 1; cause read returned the prior value.
// 5. halt=1 with tmr_pend=1 for 10 cycles -> irq_take stays 0; count unchanged.
// 6. quantum=0 over 1000 steps -> tmr_pend never set; quantum=1 -> tmr_pend every step in RUN, auto-reload verified.

Source files
------------

// File: rtl/preempt_irq_controller_pkg.sv
// Shared definitions for the preemption timer / interrupt sequencer.
// - Bit positions of the cause word.
// - Sequencer state encoding.
// - Opcodes of the interrupt-related instructions, used by the decoder.
// - Default handler entry address.
package cpu_irq_pkg;

  localparam int CAUSE_TMR = 0;
  localparam int CAUSE_KBD = 1;

  typedef enum logic {
    RUN = 1'b0,
    ISR = 1'b1
  } irq_state_t;

  localparam logic [5:0] OP_SETCLK  = 6'b000001;
  localparam logic [5:0] OP_GETIRQ  = 6'b000110;
  localparam logic [5:0] OP_SAVEPCB = 6'b110100;

  localparam logic [9:0] ISR_VECTOR_DFLT = 10'd1;

endpackage

// File: rtl/preempt_irq_controller_if.sv
// Core <-> interrupt controller bundle.
//   master (core side): drives step/halt/set_clock/set_value/get_irq/
//                       kbd_valid/pc_next; receives the controller outputs
//   slave  (controller): the reverse
// Outputs: irq_take (redirect now), isr_vector, saved_pc, cause, in_isr.
interface preempt_irq_controller_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 10
);
  logic              step;
  logic              halt;
  logic              set_clock;
  logic [DATA_W-1:0] set_value;
  logic              get_irq;
  logic              kbd_valid;
  logic [PC_W-1:0]   pc_next;

  logic              irq_take;
  logic [PC_W-1:0]   isr_vector;
  logic [PC_W-1:0]   saved_pc;
  logic [DATA_W-1:0] cause;
  logic              in_isr;

  modport master (
    output step, halt, set_clock, set_value, get_irq, kbd_valid, pc_next,
    input  irq_take, isr_vector, saved_pc, cause, in_isr
  );

  modport slave (
    input  step, halt, set_clock, set_value, get_irq, kbd_valid, pc_next,
    output irq_take, isr_vector, saved_pc, cause, in_isr
  );
endinterface

// File: rtl/preempt_irq_controller_counter.sv
// quantum_counter: retired-instruction down counter with auto reload.
//   clock, reset  : clock, async active-high reset
//   i_load        : load quantum and count from i_load_val (wins over i_dec)
//   i_load_val    : new quantum
//   i_dec         : one instruction retired while counting is allowed
//   o_expire      : this edge takes count 1 -> 0 (count reloads from quantum)
//   o_count       : current count
// A quantum of 0 leaves count at 0, which never decrements, so the timer
// is idle until the next load.
module quantum_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_expire,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_quantum;
  logic [CNT_W-1:0] r_count;
  logic             w_at_one;

  assign w_at_one = (r_count == CNT_W'(1));
  assign o_expire = ~i_load & i_dec & w_at_one;
  assign o_count  = r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_quantum <= '0;
      r_count   <= '0;
    end else if (i_load) begin
      r_quantum <= i_load_val;
      r_count   <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= w_at_one ? r_quantum : (r_count - CNT_W'(1));
    end
  end

endmodule

// File: rtl/preempt_irq_controller.sv
// Preemption timer and interrupt sequencer for the single-cycle core.
//   clock, reset : clock, async active-high reset
//   bus (slave)  : core-side controls in, redirect/status out
// Timer and keyboard events latch into pend bits; the first retired,
// non-halted instruction in RUN with a pend bit set redirects fetch to
// isr_vector (irq_take, Mealy) and captures pc_next. The handler's
// set-clock acts as the return to RUN.
module preempt_irq_controller
  import cpu_irq_pkg::*;
#(
  parameter int              DATA_W     = 32,
  parameter int              PC_W       = 10,
  parameter int              CNT_W      = 16,
  parameter logic [PC_W-1:0] ISR_VECTOR = PC_W'(ISR_VECTOR_DFLT)
) (
  input logic clock,
  input logic reset,
  preempt_irq_controller_if.slave bus
);

  irq_state_t      r_state, w_state_nxt;
  logic            r_tmr_pend, r_kbd_pend;
  logic [PC_W-1:0] r_saved_pc;

  logic w_load, w_clr, w_dec, w_take, w_expire;
  logic [CNT_W-1:0] w_count;
  logic w_unused_hi;

  assign w_load = bus.set_clock & bus.step;
  assign w_clr  = bus.get_irq & bus.step;
  // Counting is frozen inside the handler; a load on the same edge wins.
  assign w_dec  = (r_state == RUN) & bus.step & ~bus.set_clock;
  assign w_take = (r_state == RUN) & (r_tmr_pend | r_kbd_pend) & bus.step & ~bus.halt;
  assign w_unused_hi = ^bus.set_value[DATA_W-1:CNT_W];

  quantum_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (bus.set_value[CNT_W-1:0]),
    .i_dec      (w_dec),
    .o_expire   (w_expire),
    .o_count    (w_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    bus.irq_take = 1'b0;
    case (r_state)
      RUN: if (w_take) begin
        bus.irq_take = 1'b1;
        w_state_nxt  = ISR;
      end
      ISR: if (w_load) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // Set has priority over a same-edge read-clear so no event is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tmr_pend <= 1'b0;
      r_kbd_pend <= 1'b0;
    end else begin
      r_tmr_pend <= w_expire       | (r_tmr_pend & ~w_clr);
      r_kbd_pend <= bus.kbd_valid  | (r_kbd_pend & ~w_clr);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_saved_pc <= '0;
    else if (w_take) r_saved_pc <= bus.pc_next;
  end

  always_comb begin
    bus.cause            = '0;
    bus.cause[CAUSE_TMR] = r_tmr_pend;
    bus.cause[CAUSE_KBD] = r_kbd_pend;
  end

  assign bus.isr_vector = ISR_VECTOR;
  assign bus.saved_pc   = r_saved_pc;
  assign bus.in_isr     = (r_state == ISR);

endmodule

// File: tb/tb_preempt_irq_controller.sv
module tb_preempt_irq_controller;
  localparam int DATA_W = 32;
  localparam int PC_W   = 10;

  logic clock;
  logic reset;
  int checks = 0;
  int errors = 0;

  preempt_irq_controller_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

  preempt_irq_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        step, halt, setc;
    logic [31:0] val;
    logic        get, kbd;
    logic [9:0]  pc;
    logic        e_take;
    logic [31:0] e_cpre, e_cpost;
    logic        e_isr;
    logic [9:0]  e_sp;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic st, input logic hl, input logic sc, input logic [31:0] v,
                     input logic gi, input logic kb, input logic [9:0] pc);
    bus.step = st; bus.halt = hl; bus.set_clock = sc; bus.set_value = v;
    bus.get_irq = gi; bus.kbd_valid = kb; bus.pc_next = pc;
  endtask

  // Drive at negedge, check Mealy/pre-edge values, then registered ones after the edge.
  task automatic cyc(input logic st, input logic hl, input logic sc, input logic [31:0] v,
                     input logic gi, input logic kb, input logic [9:0] pc);
    @(negedge clock);
    drv(st, hl, sc, v, gi, kb, pc);
    #1;
  endtask

  task automatic post();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic bad_take, bad_pend;
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_take",   {31'd0, bus.irq_take}, 32'd0);
    chk("rst_cause",  bus.cause, 32'd0);
    chk("rst_in_isr", {31'd0, bus.in_isr}, 32'd0);
    chk("rst_vector", {22'd0, bus.isr_vector}, 32'd1);
    chk("rst_saved",  {22'd0, bus.saved_pc}, 32'd0);
    chk("rst_count",  {16'd0, dut.u_cnt.o_count}, 32'd0);

    // Test 1: reset while inside the handler with kbd pending
    cyc(1, 0, 1, 32'd5, 0, 0, 10'h04); post();
    cyc(0, 0, 0, 0, 0, 1, 10'h08);     post();
    cyc(1, 0, 0, 0, 0, 0, 10'h10);
    chk("t1_take", {31'd0, bus.irq_take}, 32'd1);
    post();
    chk("t1_in_isr", {31'd0, bus.in_isr}, 32'd1);
    chk("t1_saved", {22'd0, bus.saved_pc}, 32'h10);
    cyc(0, 0, 0, 0, 0, 1, 10'h10);     post();
    chk("t1_cause", bus.cause, 32'h2);
    chk("t1_count", {16'd0, dut.u_cnt.o_count}, 32'd4);
    @(negedge clock);
    drv(1, 0, 0, 0, 0, 0, 10'h14);
    #2 reset = 1'b1;
    #1;
    chk("t1r_in_isr", {31'd0, bus.in_isr}, 32'd0);
    chk("t1r_cause",  bus.cause, 32'd0);
    chk("t1r_take",   {31'd0, bus.irq_take}, 32'd0);
    chk("t1r_count",  {16'd0, dut.u_cnt.o_count}, 32'd0);
    chk("t1r_saved",  {22'd0, bus.saved_pc}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);

    // Tests 2-4 as a vector table
    //                   st hl sc val  gi kb pc      take cpre cpost isr sp      cnt
    tbl.push_back(vec_t'{1, 0, 1, 3,   0, 0, 10'h04, 0,   0,   0,    0,  10'h00, 3});
    tbl.push_back(vec_t'{1, 0, 0, 0,   0, 0, 10'h08, 0,   0,   0,    0,  10'h00, 2});
    tbl.push_back(vec_t'{1, 0, 0, 0,   0, 0, 10'h0C, 0,   0,   0,    0,  10'h00, 1});
    tbl.push_back(vec_t'{1, 0, 0, 0,   0, 0, 10'h10, 0,   0,   1,    0,  10'h00, 3});
    tbl.push_back(vec_t'{1, 0, 0, 0,   0, 0, 10'h24, 1,   1,   1,    1,  10'h24, 2});
    tbl.push_back(vec_t'{1, 0, 0, 0,   0, 0, 10'h04, 0,   1,   1,    1,  10'h24, 2});
    tbl.push_back(vec_t'{1, 0, 0, 0,   1, 0, 10'h08, 0,   1,   0,    1,  10'h24, 2});
    tbl.push_back(vec_t'{0, 0, 0, 0,   0, 1, 10'h0C, 0,   0,   2,    1,  10'h24, 2});
    tbl.push_back(vec_t'{1, 0, 0, 0,   0, 0, 10'h0C, 0,   2,   2,    1,  10'h24, 2});
    tbl.push_back(vec_t'{1, 0, 0, 0,   1, 0, 10'h10, 0,   2,   0,    1,  10'h24, 2});
    tbl.push_back(vec_t'{0, 0, 0, 0,   0, 1, 10'h14, 0,   0,   2,    1,  10'h24, 2});
    tbl.push_back(vec_t'{1, 0, 1, 0,   0, 0, 10'h14, 0,   2,   2,    0,  10'h24, 0});
    tbl.push_back(vec_t'{1, 0, 0, 0,   0, 0, 10'h30, 1,   2,   2,    1,  10'h30, 0});
    tbl.push_back(vec_t'{1, 0, 0, 0,   1, 1, 10'h04, 0,   2,   2,    1,  10'h30, 0});
    tbl.push_back(vec_t'{1, 0, 0, 0,   1, 0, 10'h08, 0,   2,   0,    1,  10'h30, 0});
    tbl.push_back(vec_t'{1, 0, 1, 0,   0, 0, 10'h0C, 0,   0,   0,    0,  10'h30, 0});

    foreach (tbl[i]) begin
      cyc(tbl[i].step, tbl[i].halt, tbl[i].setc, tbl[i].val, tbl[i].get, tbl[i].kbd, tbl[i].pc);
      chk($sformatf("v%0d_take", i), {31'd0, bus.irq_take}, {31'd0, tbl[i].e_take});
      chk($sformatf("v%0d_cause_pre", i), bus.cause, tbl[i].e_cpre);
      post();
      chk($sformatf("v%0d_cause", i), bus.cause, tbl[i].e_cpost);
      chk($sformatf("v%0d_in_isr", i), {31'd0, bus.in_isr}, {31'd0, tbl[i].e_isr});
      chk($sformatf("v%0d_saved", i), {22'd0, bus.saved_pc}, {22'd0, tbl[i].e_sp});
      chk($sformatf("v%0d_count", i), {16'd0, dut.u_cnt.o_count}, {16'd0, tbl[i].e_cnt});
    end

    // Test 5: halt blocks the take, pend and count persist
    cyc(1, 0, 1, 32'd2, 0, 0, 10'h04); post();
    cyc(1, 0, 0, 0, 0, 0, 10'h08);     post();
    cyc(1, 0, 0, 0, 0, 0, 10'h0C);     post();
    chk("t5_pend", bus.cause, 32'h1);
    chk("t5_count", {16'd0, dut.u_cnt.o_count}, 32'd2);
    bad_take = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 10'h10);
      if (bus.irq_take) bad_take = 1'b1;
      post();
    end
    chk("t5_halt_take", {31'd0, bad_take}, 32'd0);
    chk("t5_halt_count", {16'd0, dut.u_cnt.o_count}, 32'd2);
    chk("t5_halt_pend", bus.cause, 32'h1);
    cyc(1, 1, 0, 0, 0, 0, 10'h10);
    chk("t5_halt_step_take", {31'd0, bus.irq_take}, 32'd0);
    post();
    cyc(1, 0, 0, 0, 0, 0, 10'h44);
    chk("t5_take", {31'd0, bus.irq_take}, 32'd1);
    post();
    chk("t5_in_isr", {31'd0, bus.in_isr}, 32'd1);
    chk("t5_saved", {22'd0, bus.saved_pc}, 32'h44);
    cyc(1, 0, 0, 0, 1, 0, 10'h02);     post();
    cyc(1, 0, 1, 32'd0, 0, 0, 10'h03); post();
    chk("t5_ret", {31'd0, bus.in_isr}, 32'd0);
    chk("t5_ret_cause", bus.cause, 32'd0);

    // Test 6: quantum 0 never fires; quantum 1 fires every step
    bad_take = 1'b0;
    bad_pend = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 10'(i));
      if (bus.irq_take) bad_take = 1'b1;
      post();
      if (bus.cause[0]) bad_pend = 1'b1;
    end
    chk("t6_q0_take", {31'd0, bad_take}, 32'd0);
    chk("t6_q0_pend", {31'd0, bad_pend}, 32'd0);
    chk("t6_q0_count", {16'd0, dut.u_cnt.o_count}, 32'd0);
    cyc(1, 0, 1, 32'h0001_0001, 0, 0, 10'h04); post();
    chk("t6_q1_load", {16'd0, dut.u_cnt.o_count}, 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 10'h08);     post();
    chk("t6_q1_pend", bus.cause, 32'h1);
    chk("t6_q1_reload", {16'd0, dut.u_cnt.o_count}, 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 10'h0C);
    chk("t6_q1_take", {31'd0, bus.irq_take}, 32'd1);
    post();
    chk("t6_q1_isr", {31'd0, bus.in_isr}, 32'd1);
    chk("t6_q1_count", {16'd0, dut.u_cnt.o_count}, 32'd1);
    chk("t6_q1_saved", {22'd0, bus.saved_pc}, 32'h0C);

    @(negedge clock);
    drv(0, 0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
